sap1_prog_loader: RTL and testbench



---
 rtl/sap1_pkg.sv | 16 +
 rtl/sap1_prog_loader_if.sv | 25 ++
 rtl/sap1_prog_ram.sv | 26 ++
 rtl/sap1_prog_loader.sv | 108 ++++++++++
 tb/tb_sap1_prog_loader.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared types and sizes for the SAP-1 program loader
package sap1_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 16;

    typedef enum logic [2:0] {
        ST_HOLD = 3'd0,
        ST_LOAD = 3'd1,
        ST_CHK  = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

endpackage

// File: rtl/sap1_prog_loader_if.sv
// rtl/sap1_prog_loader_if.sv - byte stream and CPU read port bundle
// Stream: in_valid/in_data from the image source, in_ready back to it.
// CPU port: ADDR (from MAR) and CE (active-low) from the CPU, DATA_OUT back.
// master = image source + CPU side, slave = loader side.
interface sap1_prog_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] ADDR;
    logic              CE;
    logic [DATA_W-1:0] DATA_OUT;

    modport master (
        output in_valid, in_data, ADDR, CE,
        input  in_ready, DATA_OUT
    );

    modport slave (
        input  in_valid, in_data, ADDR, CE,
        output in_ready, DATA_OUT
    );
endinterface

// File: rtl/sap1_prog_ram.sv
// rtl/sap1_prog_ram.sv - 16x8 program/data memory, sync write, async read
// Ports: clk; we/waddr/wdata write port (takes effect on rising edge);
//        raddr/rdata combinational read port. Contents are not reset.
module sap1_prog_ram
    import sap1_pkg::*;
#(
    parameter int RAM_ADDR_W = 4,
    parameter int RAM_DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [RAM_ADDR_W-1:0] waddr,
    input  logic [RAM_DATA_W-1:0] wdata,
    input  logic [RAM_ADDR_W-1:0] raddr,
    output logic [RAM_DATA_W-1:0] rdata
);
    logic [RAM_DATA_W-1:0] mem [1 << RAM_ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sap1_prog_loader.sv
// rtl/sap1_prog_loader.sv - SAP-1 program loader, checksum gate and ROM port
// Ports: clk; rst (async, active-low); start (reload request, honoured in
//        HOLD/RUN/ERR); bus (slave: byte stream in, CPU read port out);
//        cpu_rst (high except in RUN); busy (LOAD/CHK); done (one-cycle
//        pulse after a good checksum); err (high in ERR).
module sap1_prog_loader
    import sap1_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    sap1_prog_loader_if.slave    bus,
    output logic                 cpu_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q;
    logic [DATA_W-1:0]   sum_q;
    logic                done_q;
    logic                xfer;
    logic                load_entry;
    logic [DATA_W-1:0]   chk_sum;
    logic [DATA_W-1:0]   ram_rdata;
    logic                ram_we;

    assign xfer       = bus.in_valid && bus.in_ready;
    assign load_entry = start && (state_q == ST_HOLD || state_q == ST_RUN || state_q == ST_ERR);
    // Running sum including the byte on the bus; zero means a valid image.
    assign chk_sum    = sum_q + bus.in_data;
    assign ram_we     = (state_q == ST_LOAD) && xfer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD, ST_RUN, ST_ERR: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (xfer && cnt_q == '1) state_d = ST_CHK;
            end
            ST_CHK: begin
                if (xfer) state_d = (chk_sum == '0) ? ST_RUN : ST_ERR;
            end
            default: state_d = ST_HOLD;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        cpu_rst      = 1'b1;
        err          = 1'b0;
        case (state_q)
            ST_LOAD, ST_CHK: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
            end
            ST_RUN:  cpu_rst = 1'b0;
            ST_ERR:  err     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            sum_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == ST_CHK) && xfer && (chk_sum == '0);
            if (load_entry) begin
                cnt_q <= '0;
                sum_q <= '0;
            end else if (ram_we) begin
                // cnt wraps to 0 on the 16th byte, ready for the next load
                cnt_q <= cnt_q + ADDR_W'(1);
                sum_q <= chk_sum;
            end
        end
    end

    assign done = done_q;

    sap1_prog_ram #(
        .RAM_ADDR_W (ADDR_W),
        .RAM_DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (cnt_q),
        .wdata (bus.in_data),
        .raddr (bus.ADDR),
        .rdata (ram_rdata)
    );

    // Reads are gated to RUN so the CPU never sees a partial image.
    assign bus.DATA_OUT = (state_q == ST_RUN && !bus.CE) ? ram_rdata : '0;
endmodule

// File: tb/tb_sap1_prog_loader.sv
// tb/tb_sap1_prog_loader.sv - self-checking bench for sap1_prog_loader
module tb_sap1_prog_loader;
    logic clk;
    logic rst;
    logic start;
    logic cpu_rst;
    logic busy;
    logic done;
    logic err;

    int checks;
    int errors;

    logic [7:0] img [17];
    logic [7:0] model_mem [16];
    bit         model_run;

    sap1_prog_loader_if bus ();

    sap1_prog_loader dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus.slave),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit image_ok();
        int s;
        s = 0;
        for (int i = 0; i < 17; i++) s += img[i];
        return (s % 256) == 0;
    endfunction

    function automatic void random_image(input bit good);
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            img[i] = 8'($urandom_range(0, 255));
            s += img[i];
        end
        img[16] = 8'((256 - (s % 256)) % 256);
        if (!good) img[16] = img[16] + 8'($urandom_range(1, 255));
    endfunction

    // Caller is at a negedge inside a cycle where the loader is in LOAD.
    task automatic send_bytes(input int n, input bit gaps, input int inject_at);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = 8'($urandom_range(0, 255));
                    @(negedge clk);
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = img[i];
            start        = (i == inject_at);
            check("in_ready_during_load", bus.in_ready, 1'b1);
            if (i < 16) model_mem[i] = img[i];
            @(negedge clk);
            start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic full_load(input bit gaps, input int inject_at);
        bit ok;
        ok = image_ok();
        send_bytes(17, gaps, inject_at);
        check("post_done", done, ok);
        check("post_cpu_rst", cpu_rst, !ok);
        check("post_err", err, !ok);
        check("post_in_ready", bus.in_ready, 1'b0);
        check("post_busy", busy, 1'b0);
        model_run = ok;
        @(negedge clk);
        check("done_drops", done, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_ready", bus.in_ready, 1'b1);
        check("start_busy", busy, 1'b1);
        check("start_cpu_rst", cpu_rst, 1'b1);
        check("start_err", err, 1'b0);
    endtask

    task automatic check_reads();
        for (int a = 0; a < 16; a++) begin
            bus.ADDR = 4'(a);
            bus.CE   = 1'b0;
            #1;
            check("read_ce0", bus.DATA_OUT, model_run ? model_mem[a] : 8'h00);
            bus.CE = 1'b1;
            #1;
            check("read_ce1", bus.DATA_OUT, 8'h00);
        end
        bus.CE = 1'b1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        model_run    = 1'b0;
        rst          = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.ADDR     = 4'h0;
        bus.CE       = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_cpu_rst", cpu_rst, 1'b1);
        check("rst_data_out", bus.DATA_OUT, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        check("hold_cpu_rst", cpu_rst, 1'b1);

        // 16 x 01 with checksum F0
        for (int i = 0; i < 16; i++) img[i] = 8'h01;
        img[16] = 8'hF0;
        pulse_start();
        full_load(1'b0, -1);
        bus.ADDR = 4'd5;
        bus.CE   = 1'b0;
        #1;
        check("ones_addr5", bus.DATA_OUT, 8'h01);
        check_reads();

        // Bad checksum image
        img[0] = 8'h09; img[1] = 8'h1A; img[2] = 8'h2B; img[3] = 8'hE0; img[4] = 8'hF0;
        for (int i = 5; i < 16; i++) img[i] = 8'hFF;
        img[16] = 8'h00;
        pulse_start();
        full_load(1'b0, -1);
        check("bad_err", err, 1'b1);
        check_reads();

        // From ERR: start then correct load with random gaps
        random_image(1'b1);
        pulse_start();
        full_load(1'b1, -1);
        check("err_recover_run", cpu_rst, 1'b0);
        check_reads();

        // Reset after 5 bytes
        random_image(1'b1);
        pulse_start();
        send_bytes(5, 1'b0, -1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_in_ready", bus.in_ready, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_cpu_rst", cpu_rst, 1'b1);
        check("midrst_data_out", bus.DATA_OUT, 8'h00);
        model_run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_hold", bus.in_ready, 1'b0);
        random_image(1'b1);
        pulse_start();
        full_load(1'b1, -1);
        check_reads();

        // RUN: start together with a valid byte, then start mid-load
        start        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        @(negedge clk);
        start        = 1'b0;
        bus.in_valid = 1'b0;
        check("run_start_cpu_rst", cpu_rst, 1'b1);
        check("run_start_busy", busy, 1'b1);
        random_image(1'b1);
        full_load(1'b1, 7);
        check_reads();

        // Randomized images, good or bad checksum
        for (int t = 0; t < 6; t++) begin
            random_image($urandom_range(0, 1) == 1);
            pulse_start();
            full_load($urandom_range(0, 1) == 1, -1);
            check_reads();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
